// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, R-type funct codes and the funct->Opin decode.
// Used by the operand issue stage and the ALU bench.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic       legal;
    logic [3:0] op;
  } dec_t;

  function automatic dec_t decode_funct(input logic [5:0] funct);
    dec_t d;
    d.legal = 1'b1;
    d.op    = OP_ADD;
    case (funct)
      FN_ADD:  d.op = OP_ADD;
      FN_SUB:  d.op = OP_SUB;
      FN_AND:  d.op = OP_AND;
      FN_OR:   d.op = OP_OR;
      FN_XOR:  d.op = OP_XOR;
      FN_NOR:  d.op = OP_NOR;
      FN_SLT:  d.op = OP_SLT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port where ALU writeback
// beats a direct load. r0 always reads zero.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (wb_en) begin
      if (wb_addr != '0) r_mem[wb_addr] <= wb_data;
    end else if (ld_en) begin
      if (ld_addr != '0) r_mem[ld_addr] <= ld_data;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : r_mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : r_mem[rb_addr];
endmodule

// File: rtl/alu_operand_issue.sv
// ALU issue stage: accepts R-type ops, reads operands, drives the ALU and writes
// the result back. RAW hazards against in-flight destinations stall the input.
module alu_operand_issue
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_Opin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              illegal
);
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
  } trk_t;

  // Entry i holds the op whose ALU inputs were presented i cycles ago;
  // the last entry marks the writeback edge.
  trk_t [ALU_LAT:0] r_trk;

  logic [DATA_W-1:0] r_alu_A, r_alu_B;
  logic [3:0]        r_alu_Opin;
  logic              r_wb_valid, r_wb_zero, r_illegal;
  logic [REG_AW-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_haz, w_acc, w_wb_due;
  dec_t              w_dec;
  logic [DATA_W-1:0] w_rs_data, w_rt_data;

  assign w_dec    = decode_funct(in_funct);
  assign w_wb_due = r_trk[ALU_LAT].vld;
  assign in_ready = ~w_haz;
  assign w_acc    = in_valid & in_ready;
  assign ld_ready = ~w_wb_due;

  // r0 sources never stall: r0 is constant regardless of pending writes.
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i <= ALU_LAT; i++) begin
      if (r_trk[i].vld &&
          (((in_rs != '0) && (in_rs == r_trk[i].rd)) ||
           ((in_rt != '0) && (in_rt == r_trk[i].rd))))
        w_haz = 1'b1;
    end
  end

  alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk     (clk),
    .rst     (reset),
    .ra_addr (in_rs),
    .ra_data (w_rs_data),
    .rb_addr (in_rt),
    .rb_data (w_rt_data),
    .wb_en   (w_wb_due),
    .wb_addr (r_trk[ALU_LAT].rd),
    .wb_data (alu_result),
    .ld_en   (ld_valid & ld_ready),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trk <= '0;
    end else begin
      r_trk[0].vld <= w_acc & w_dec.legal;
      r_trk[0].rd  <= in_rd;
      for (int i = 1; i <= ALU_LAT; i++) r_trk[i] <= r_trk[i-1];
    end
  end

  // Illegal ops are consumed without touching the ALU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_A    <= '0;
      r_alu_B    <= '0;
      r_alu_Opin <= OP_ADD;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= w_acc & ~w_dec.legal;
      if (w_acc && w_dec.legal) begin
        r_alu_A    <= w_rs_data;
        r_alu_B    <= w_rt_data;
        r_alu_Opin <= w_dec.op;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_zero  <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_due;
      if (w_wb_due) begin
        r_wb_rd   <= r_trk[ALU_LAT].rd;
        r_wb_data <= alu_result;
        r_wb_zero <= alu_zero;
      end
    end
  end

  assign alu_A    = r_alu_A;
  assign alu_B    = r_alu_B;
  assign alu_Opin = r_alu_Opin;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign wb_zero  = r_wb_zero;
  assign illegal  = r_illegal;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue paired with a one-cycle behavioural ALU.
// Writebacks are checked against a scoreboard queue filled at issue time.
module tb_alu_operand_issue;
  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [5:0]    in_funct;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] alu_A, alu_B;
  logic [3:0]    alu_Opin;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          wb_valid, wb_zero, illegal;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          zero;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   wb_seen = 0;

  always #5 clk = ~clk;

  alu_operand_issue #(.DATA_W(DW), .REG_AW(AW), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Opin(alu_Opin),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero),
    .illegal(illegal)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~(a | b);
      4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // One-cycle ALU: inputs seen during cycle N+1 give a result sampled at edge N+2.
  always @(posedge clk) begin
    alu_result <= alu_f(alu_A, alu_B, alu_Opin);
    alu_zero   <= (alu_f(alu_A, alu_B, alu_Opin) == '0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && wb_valid) begin
      wb_seen++;
      n_chk++;
      if (sbq.size() == 0) begin
        $display("FAIL wb_unexpected got rd=%0d data=%h zero=%b, none expected", wb_rd, wb_data, wb_zero);
      end else begin
        e = sbq.pop_front();
        if ({wb_rd, wb_data, wb_zero} !== e)
          $display("FAIL wb_scoreboard got rd=%0d data=%h zero=%b exp rd=%0d data=%h zero=%b",
                   wb_rd, wb_data, wb_zero, e.rd, e.data, e.zero);
        else n_pass++;
      end
    end
  end

  // Presents an op, waits (bounded) for in_ready, returns just after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [AW-1:0] s, input logic [AW-1:0] t,
                       input logic [AW-1:0] d, input logic push, input logic [DW-1:0] ed,
                       output int stalls);
    stalls = 0;
    in_valid = 1'b1; in_funct = f; in_rs = s; in_rt = t; in_rd = d;
    @(negedge clk);
    while (!in_ready && stalls < 20) begin stalls++; @(negedge clk); end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL issue_timeout funct=%h rs=%0d rt=%0d still stalled after %0d cycles", f, s, t, stalls);
    end else if (push) begin
      sbq.push_back('{rd: d, data: ed, zero: (ed == '0)});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    while (!ld_ready && k < 20) begin k++; @(negedge clk); end
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 20) begin k++; @(negedge clk); end
    repeat (2) @(negedge clk);
    n_chk++;
    if (sbq.size() != 0) $display("FAIL drain_timeout %0d writebacks missing, required 0", sbq.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({alu_A, alu_B, alu_Opin, wb_valid, wb_rd, wb_data, wb_zero, illegal} !== '0)
      $display("FAIL reset_outputs got A=%h B=%h Op=%b wbv=%b wbd=%h ill=%b, required 0",
               alu_A, alu_B, alu_Opin, wb_valid, wb_data, illegal);
    else n_pass++;
    n_chk++;
    if ({in_ready, ld_ready} !== 2'b11) $display("FAIL reset_ready got %b required 11", {in_ready, ld_ready});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_and_timing();
    int st;
    load(3'd1, 32'h1B);
    load(3'd2, 32'h2E);
    issue(6'h24, 3'd1, 3'd2, 3'd3, 1'b1, 32'h0A, st);
    @(negedge clk);
    n_chk++;
    if ({alu_Opin, alu_A, alu_B} !== {4'b0100, 32'h1B, 32'h2E})
      $display("FAIL and_issue got Op=%b A=%h B=%h required 0100 1b 2e", alu_Opin, alu_A, alu_B);
    else n_pass++;
    n_chk++;
    if (wb_valid !== 1'b0) $display("FAIL and_wb_early got wb_valid=%b required 0 in N+1", wb_valid);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (wb_valid !== 1'b1) $display("FAIL and_wb_timing got wb_valid=%b required 1 in N+3", wb_valid);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0]    fn [6] = '{6'h20, 6'h25, 6'h26, 6'h27, 6'h22, 6'h2A};
    logic [DW-1:0] ex [6] = '{32'h49, 32'h3F, 32'h35, 32'hFFFFFFC0, 32'hFFFFFFED, 32'h1};
    int st;
    for (int i = 0; i < 6; i++) begin
      issue(fn[i], 3'd1, 3'd2, 3'd3, 1'b1, ex[i], st);
      n_chk++;
      if (st !== 0) $display("FAIL b2b_stall op%0d got %0d stall cycles required 0", i, st);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_hazard();
    int st;
    issue(6'h20, 3'd1, 3'd2, 3'd4, 1'b1, 32'h49, st);
    issue(6'h22, 3'd4, 3'd1, 3'd5, 1'b1, 32'h2E, st);
    n_chk++;
    if (st !== 2) $display("FAIL raw_stall got %0d stall cycles required 2", st);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (alu_A !== 32'h49) $display("FAIL raw_operand got alu_A=%h required 00000049", alu_A);
    else n_pass++;
    drain();
  endtask

  task automatic test_zero_r0();
    int st;
    issue(6'h22, 3'd1, 3'd1, 3'd6, 1'b1, 32'h0, st);
    issue(6'h20, 3'd1, 3'd2, 3'd0, 1'b1, 32'h49, st);
    issue(6'h25, 3'd0, 3'd2, 3'd7, 1'b1, 32'h2E, st);
    n_chk++;
    if (st !== 0) $display("FAIL r0_nostall got %0d stall cycles required 0", st);
    else n_pass++;
    drain();
  endtask

  task automatic test_illegal();
    int st, seen0;
    seen0 = wb_seen;
    issue(6'h3F, 3'd1, 3'd1, 3'd2, 1'b0, 32'h0, st);
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b1) $display("FAIL illegal_pulse got %b required 1", illegal);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (illegal !== 1'b0) $display("FAIL illegal_width got %b required 0 on second cycle", illegal);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wb_seen !== seen0) $display("FAIL illegal_wb got %0d writebacks required 0", wb_seen - seen0);
    else n_pass++;
    @(posedge clk); #1;
    issue(6'h25, 3'd2, 3'd0, 3'd3, 1'b1, 32'h2E, st);
    drain();
  endtask

  task automatic test_reset_midstream();
    int st, seen0;
    issue(6'h20, 3'd1, 3'd2, 3'd3, 1'b0, 32'h0, st);
    issue(6'h25, 3'd1, 3'd2, 3'd4, 1'b0, 32'h0, st);
    seen0 = wb_seen;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({alu_A, alu_B, alu_Opin, wb_valid, wb_rd, wb_data, wb_zero, illegal} !== '0)
      $display("FAIL midreset_outputs got A=%h B=%h Op=%b wbv=%b wbd=%h, required 0",
               alu_A, alu_B, alu_Opin, wb_valid, wb_data);
    else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (wb_seen !== seen0) $display("FAIL midreset_wb got %0d writebacks required 0", wb_seen - seen0);
    else n_pass++;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL midreset_ready got %b required 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    issue(6'h25, 3'd1, 3'd2, 3'd3, 1'b1, 32'h0, st);
    issue(6'h25, 3'd7, 3'd6, 3'd4, 1'b1, 32'h0, st);
    drain();
  endtask

  initial begin
    test_reset();
    test_and_timing();
    test_back_to_back();
    test_hazard();
    test_zero_r0();
    test_illegal();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end
endmodule
